// File: rtl/uart_imem_loader.sv
// UART (8N1) program loader: packs received bytes little-endian into 32-bit words and writes them to the IM.
// Optional feature: define UART_LOADER_CHECKSUM_EN to add checksum_o (wrapping sum of written words).
module uart_imem_loader #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx_i,
  input  logic              load_en_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic [ADDR_W:0]   word_cnt_o
`ifdef UART_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W + 1)'((1 << ADDR_W) - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       byte_idx_q;
  logic [23:0]      word_q;
  logic             rx_meta, rx_s;
  logic             load_en_q;
  logic             byte_ok_c, ferr_c, arm_c;

  assign arm_c = load_en_i & ~load_en_q;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_ok_c = 1'b0;
    ferr_c    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s && load_en_i && !done_o) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d     = '0;
          state_d   = IDLE;
          byte_ok_c = rx_s;
          ferr_c    = ~rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disarm aborts any frame in flight
    if (!load_en_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      byte_ok_c = 1'b0;
      ferr_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      load_en_q   <= 1'b0;
      we_o        <= 1'b0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
      word_cnt_o  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      checksum_o  <= '0;
`endif
    end else begin
      load_en_q <= load_en_i;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      busy_o    <= (state_d != IDLE);
      we_o      <= 1'b0;
      if (arm_c) begin
        waddr_o     <= '0;
        word_cnt_o  <= '0;
        byte_idx_q  <= '0;
        done_o      <= 1'b0;
        frame_err_o <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        checksum_o  <= '0;
`endif
      end else begin
        if (!load_en_i) byte_idx_q <= '0;
        if (ferr_c) frame_err_o <= 1'b1;
        // Fourth byte completes the word; the write strobe follows in the next cycle
        if (byte_ok_c) begin
          if (byte_idx_q == 2'd3) begin
            we_o       <= 1'b1;
            wdata_o    <= {shift_q, word_q};
            byte_idx_q <= '0;
          end else begin
            case (byte_idx_q)
              2'd0:    word_q[7:0]   <= shift_q;
              2'd1:    word_q[15:8]  <= shift_q;
              default: word_q[23:16] <= shift_q;
            endcase
            byte_idx_q <= byte_idx_q + 1'b1;
          end
        end
        if (we_o) begin
          waddr_o    <= waddr_o + 1'b1;
          word_cnt_o <= word_cnt_o + 1'b1;
          if (word_cnt_o == CNT_LAST) done_o <= 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
          checksum_o <= checksum_o + wdata_o;
`endif
        end
      end
    end
  end

endmodule
